// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator with a small valid/ready output buffer.
//
// Each accepted instruction is decoded on the way in. The decoded immediate,
// format code and illegal flag are stored in a DEPTH-entry circular buffer and
// presented in acceptance order. While the buffer is empty the outputs read as
// imm 0 / fmt 7 / illegal 0.
//
// Optional feature: define IMM_GEN_ERRCNT_EN to add the err_cnt port. It
// counts accepted unsupported opcodes and saturates at 16'hFFFF.

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
`ifdef IMM_GEN_ERRCNT_EN
  ,
  output logic [15:0]     err_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Decoder outputs for the instruction currently on in_instr
  logic [6:0]      opcode;
  logic            sgn;
  logic [63:0]     dec_imm64;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  // Buffer storage and bookkeeping
  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [2:0]       fmt_q [DEPTH];
  logic             ill_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_C) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Decode is always done at full 64-bit width; XLEN=32 keeps the low word,
  // which is the same value because every format sign-extends from bit 31.
  always_comb begin
    opcode      = in_instr[6:0];
    sgn         = in_instr[31];
    dec_imm64   = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b1;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_imm64   = {{52{sgn}}, in_instr[31:20]};
        dec_fmt     = FMT_I;
        dec_illegal = 1'b0;
      end
      OP_STORE: begin
        dec_imm64   = {{52{sgn}}, in_instr[31:25], in_instr[11:7]};
        dec_fmt     = FMT_S;
        dec_illegal = 1'b0;
      end
      OP_BRANCH: begin
        dec_imm64   = {{51{sgn}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
        dec_fmt     = FMT_B;
        dec_illegal = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm64   = {{32{sgn}}, in_instr[31:12], 12'b0};
        dec_fmt     = FMT_U;
        dec_illegal = 1'b0;
      end
      OP_JAL: begin
        dec_imm64   = {{43{sgn}}, in_instr[31], in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
        dec_fmt     = FMT_J;
        dec_illegal = 1'b0;
      end
      default: begin
        dec_imm64   = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b1;
      end
    endcase
    dec_imm = dec_imm64[XLEN-1:0];
  end

  // in_ready looks only at occupancy and reset, never at out_ready, so a full
  // buffer frees a slot one cycle after the release.
  assign in_ready  = rst_n && (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry is presented directly; an empty buffer shows the idle values
  assign out_imm     = out_valid ? imm_q[rd_ptr_q] : '0;
  assign out_fmt     = out_valid ? fmt_q[rd_ptr_q] : FMT_NONE;
  assign out_illegal = out_valid ? ill_q[rd_ptr_q] : 1'b0;

  // Next-state pointers and occupancy; push and pop together leave count as is
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the buffer, dropping any entries
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload written on accept; unread contents are masked by out_valid
  always_ff @(posedge clk) begin
    if (push) begin
      imm_q[wr_ptr_q] <= dec_imm;
      fmt_q[wr_ptr_q] <= dec_fmt;
      ill_q[wr_ptr_q] <= dec_illegal;
    end
  end

`ifdef IMM_GEN_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count accepted unsupported opcodes, holding at all-ones
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && dec_illegal && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share one stimulus
// stream and are checked every cycle against a queue-based reference model.
module tb_imm_gen_pipe;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'h0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
`ifdef IMM_GEN_ERRCNT_EN
  logic [15:0] err_cnt32, err_cnt64;
`endif

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32)
`ifdef IMM_GEN_ERRCNT_EN
    , .err_cnt(err_cnt32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
`ifdef IMM_GEN_ERRCNT_EN
    , .err_cnt(err_cnt64)
`endif
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } res_t;

  res_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_err = 0;
  bit   started = 0;
  int   dut_rel = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
    longint v;
    v = longint'(w) & 64'h0000_0000_FFFF_FFFF;
    return (v >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction

  function automatic longint sx(input longint f, input int bits);
    if (f >= (longint'(1) << (bits - 1))) return f - (longint'(1) << bits);
    return f;
  endfunction

  // Reference decode: assemble the offset value arithmetically, then sign-extend
  function automatic res_t model(input logic [31:0] w);
    res_t   r;
    longint v;
    int     op;
    op    = int'(fld(w, 6, 0));
    r.fmt = 3'd7;
    r.ill = 1'b1;
    v     = 0;
    case (op)
      'h13, 'h03, 'h67: begin r.fmt = 3'd0; r.ill = 1'b0; v = sx(fld(w, 31, 20), 12); end
      'h23: begin
        r.fmt = 3'd1; r.ill = 1'b0;
        v = sx(fld(w, 31, 25) * 32 + fld(w, 11, 7), 12);
      end
      'h63: begin
        r.fmt = 3'd2; r.ill = 1'b0;
        v = sx(fld(w, 31, 31) * 4096 + fld(w, 7, 7) * 2048 +
               fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2, 13);
      end
      'h37, 'h17: begin r.fmt = 3'd3; r.ill = 1'b0; v = sx(fld(w, 31, 12) * 4096, 32); end
      'h6F: begin
        r.fmt = 3'd4; r.ill = 1'b0;
        v = sx(fld(w, 31, 31) * (1 << 20) + fld(w, 19, 12) * (1 << 12) +
               fld(w, 20, 20) * (1 << 11) + fld(w, 30, 21) * 2, 21);
      end
      default: v = 0;
    endcase
    r.imm = 64'(v);
    return r;
  endfunction

  // Model update on each edge, using its own occupancy to decide accept/release
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_err   = 0;
      started = 1;
    end else if (started) begin
      bit   acc, rel;
      res_t r;
      acc = in_valid && (q.size() < DEPTH);
      rel = out_ready && (q.size() > 0);
      if (rel) void'(q.pop_front());
      if (acc) begin
        r = model(in_instr);
        q.push_back(r);
        if (r.ill && m_err < 65535) m_err++;
      end
    end
    if (out_valid32 && out_ready) dut_rel++;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("in_ready32", in_ready32, 64'(rst_n && (q.size() < DEPTH)));
      check("in_ready64", in_ready64, 64'(rst_n && (q.size() < DEPTH)));
      check("out_valid32", out_valid32, 64'(q.size() > 0));
      check("out_valid64", out_valid64, 64'(q.size() > 0));
      if (q.size() > 0) begin
        check("out_imm32", out_imm32, {32'h0, q[0].imm[31:0]});
        check("out_imm64", out_imm64, q[0].imm);
        check("out_fmt32", out_fmt32, q[0].fmt);
        check("out_fmt64", out_fmt64, q[0].fmt);
        check("out_illegal32", out_illegal32, q[0].ill);
        check("out_illegal64", out_illegal64, q[0].ill);
      end
`ifdef IMM_GEN_ERRCNT_EN
      check("err_cnt32", err_cnt32, 64'(m_err));
      check("err_cnt64", err_cnt64, 64'(m_err));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec [10] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h0000006F,
                            32'h800000B7, 32'h00001097, 32'h00008067, 32'hFFC12083,
                            32'hFE112E23, 32'hFF5FF06F};

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int   rel0;

    // Reference-model pins against hand-decoded encodings
    r = model(32'hFFF00093); check("model_addi", r.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    r = model(32'h800000B7); check("model_lui", r.imm, 64'hFFFF_FFFF_8000_0000);
    r = model(32'h00112623); check("model_sw", r.imm, 64'd12);
    r = model(32'h00001097); check("model_auipc", r.imm, 64'h1000);
    // beq x0,x0,-4: instr[7]=1 supplies imm[11], giving offset -4
    r = model(32'hFE000EE3); check("model_beq", r.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    r = model(32'hFF5FF06F); check("model_jal", r.imm, 64'hFFFF_FFFF_FFFF_FFF4);
    r = model(32'hFFFFFFFF); check("model_illegal_fmt", r.fmt, 64'd7);

    // Reset state
    rst_n = 0; in_valid = 0; out_ready = 0;
    step(); step();
    @(negedge clk);
    check("rst_in_ready", in_ready32, 0);
    check("rst_out_valid", out_valid32, 0);
    check("rst_out_imm", out_imm64, 0);
    check("rst_out_fmt", out_fmt32, 7);
    check("rst_out_illegal", out_illegal32, 0);
    step();
    rst_n = 1;
    step();

    // addi x1,x0,-1 with latency 1
    out_ready = 1; in_valid = 1; in_instr = 32'hFFF00093;
    step();
    in_valid = 0;
    @(negedge clk);
    check("addi_valid", out_valid32, 1);
    check("addi_imm32", out_imm32, 64'hFFFF_FFFF);
    check("addi_fmt", out_fmt32, 0);
    check("addi_illegal", out_illegal32, 0);
    step();

    // lui on the 64-bit instance
    in_valid = 1; in_instr = 32'h800000B7;
    step();
    in_valid = 0;
    @(negedge clk);
    check("lui_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    check("lui_imm32", out_imm32, 64'h8000_0000);
    check("lui_fmt", out_fmt64, 3);
    step();

    // Fill DEPTH=2 with out_ready low, hold, then release one
    out_ready = 0; in_valid = 1; in_instr = 32'hFE000EE3;
    step();
    in_instr = 32'h0000006F;
    step();
    in_instr = 32'h00112623;
    @(negedge clk);
    check("full_in_ready32", in_ready32, 0);
    check("full_in_ready64", in_ready64, 0);
    check("beq_imm32", out_imm32, 64'hFFFF_FFFC);
    check("beq_fmt", out_fmt32, 2);
    step();
    out_ready = 1;
    step();
    out_ready = 0;
    @(negedge clk);
    check("jal_imm32", out_imm32, 0);
    check("jal_fmt", out_fmt32, 4);
    check("resume_in_ready", in_ready32, 1);
    step();
    in_valid = 0; out_ready = 1;
    step(); step(); step();

    // Occupancy 1 with simultaneous accept/release for 10 cycles
    out_ready = 0; in_valid = 1; in_instr = 32'h00001097;
    step();
    out_ready = 1;
    rel0 = dut_rel;
    for (int i = 0; i < 10; i++) begin
      in_instr = vec[i];
      step();
    end
    in_valid = 0;
    check("stream_releases", 64'(dut_rel - rel0), 10);
    check("stream_occupied", out_valid32, 1);
    step(); step();

    // Unsupported opcode three times
    in_valid = 1; in_instr = 32'hFFFFFFFF;
    repeat (3) step();
    in_valid = 0;
    @(negedge clk);
    check("ill_flag", out_illegal32, 1);
    check("ill_fmt", out_fmt64, 7);
    check("ill_imm", out_imm64, 0);
`ifdef IMM_GEN_ERRCNT_EN
    check("ill_err_cnt", err_cnt32, 3);
`endif
    step();

    // Reset with a full buffer: nothing survives
    out_ready = 0; in_valid = 1; in_instr = 32'hFFFFFFFF;
    step();
    in_instr = 32'h00112623;
    step();
    in_valid = 0; rst_n = 0;
    step();
    @(negedge clk);
    check("midrst_out_valid", out_valid32, 0);
    check("midrst_in_ready", in_ready64, 0);
    check("midrst_out_fmt", out_fmt32, 7);
`ifdef IMM_GEN_ERRCNT_EN
    check("midrst_err_cnt", err_cnt64, 0);
`endif
    step();
    rst_n = 1; out_ready = 1;
    step(); step();
    @(negedge clk);
    check("post_rst_empty", out_valid64, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
